// File: rtl/uart_pkg.sv
// UART receiver shared types: FSM state encoding, delimiter byte,
// and the clocks-per-bit helper used to size the bit timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  localparam logic [7:0] UART_DELIM = 8'h24;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// UART receive bundle: serial rx in, framed byte and status pulses out.
// master = receiver side, slave = consumer (instruction RAM loader).
interface uart_rx_byte_if #(
  parameter int N = 8
);
  logic         rx;
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         delim;
  logic         frame_err;
  logic         busy;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
`endif

  modport master (
    input  rx,
    output data_out,
    output data_valid,
    output delim,
    output frame_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  modport slave (
    output rx,
    input  data_out,
    input  data_valid,
    input  delim,
    input  frame_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );

endinterface

// File: rtl/uart_rx_byte_sync.sv
// Two-flop synchroniser for one async bit, with a reset preset value.
// Ports: clk, rst (sync, active-low), d (async in), q (synced out).
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined).
// Ports: clk, rst (sync, active-low), bus (uart_rx_byte_if.master):
//   rx in; data_out, data_valid, delim, frame_err, busy
//   (+ parity_err when UART_RX_PARITY_EN) out.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int N        = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.master bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [N-1:0]  DELIM    = N'(UART_DELIM);

  if (CLKS_PER_BIT < 4) begin : g_cpb_chk
    $error("uart_rx_byte: CLKS_PER_BIT must be >= 4");
  end

  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bit_cnt;
  logic [N-1:0]   shift;
  logic [N-1:0]   data_q;
  logic           valid_q;
  logic           delim_q;
  logic           ferr_q;
  logic           busy_q;
  logic           rx_s;
`ifdef UART_RX_PARITY_EN
  logic           par_q;
  logic           perr_q;
`endif

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      delim_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      delim_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        // Half-bit re-check rejects glitches and
        // centres every later sample in its bit.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[N-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            par_q <= rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q <= ^{shift, par_q};
`endif
            if (!rx_s) begin
              ferr_q <= 1'b1;
              state  <= BREAK;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (!(^{shift, par_q})) begin
                data_q  <= shift;
                valid_q <= 1'b1;
                delim_q <= (shift == DELIM);
              end
`else
              data_q  <= shift;
              valid_q <= 1'b1;
              delim_q <= (shift == DELIM);
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Line held low after a bad stop: stay
        // parked until it returns to idle-high.
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.delim      = delim_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboarded random bench for uart_rx_byte at 16 clocks per bit.
// Frame sender pushes expected pulses; negedge monitor pops and checks.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = 16;
  localparam int N        = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_byte_if #(.N(N)) bus ();

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .N        (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // kind: 0 good byte, 1 framing error, 2 parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         total = 0;
  int         bad = 0;
  logic       perr;

`ifdef UART_RX_PARITY_EN
  assign perr = bus.parity_err;
`else
  assign perr = 1'b0;
`endif

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic idle(int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic line_bit(logic v);
    bus.rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Reference model: a frame with a low stop bit is a framing error,
  // a bad parity bit (parity builds) is a parity error, else the byte
  // becomes the new held value.
  task automatic send(logic [7:0] b, logic stop, logic par_flip);
    exp_t e;
    logic par_bad;
    par_bad = par_flip & PAR_EN;
    if (!stop) begin
      e.kind = 1;
      e.data = last_good;
    end else if (par_bad) begin
      e.kind = 2;
      e.data = last_good;
    end else begin
      e.kind = 0;
      e.data = b;
      last_good = b;
    end
    exp_q.push_back(e);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    if (PAR_EN) line_bit((^b) ^ par_flip);
    line_bit(stop);
  endtask

  always @(negedge clk) begin
    logic [2:0] act;
    logic [2:0] want;
    exp_t       e;
    act = {bus.data_valid, bus.frame_err, perr};
    if (rst && (act != 3'b000 || bus.delim)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {28'd0, bus.delim, act}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        want = (e.kind == 0) ? 3'b100 :
               (e.kind == 1) ? 3'b010 : 3'b001;
        check("pulse_kind", act, want);
        check("data_out", bus.data_out, e.data);
        check("delim", bus.delim,
              (e.kind == 0) && (e.data == UART_DELIM));
      end
    end
  end

  initial begin
    bus.rx = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data_out", bus.data_out, 8'h00);
    check("rst_valid", bus.data_valid, 1'b0);
    check("rst_delim", bus.delim, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    idle(CPB);

    send(8'h41, 1'b1, 1'b0);
    idle(CPB);
    check("t1_data", bus.data_out, 8'h41);
    check("t1_busy", bus.busy, 1'b0);

    send(8'h24, 1'b1, 1'b0);
    idle(CPB);
    check("t2_data", bus.data_out, 8'h24);

    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_busy", bus.busy, 1'b0);
    check("t3_data", bus.data_out, 8'h24);

    send(8'h55, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    check("t4_break_busy", bus.busy, 1'b1);
    check("t4_data_held", bus.data_out, 8'h24);
    idle(CPB);
    check("t4_break_exit", bus.busy, 1'b0);
    send(8'h0F, 1'b1, 1'b0);
    idle(CPB);
    check("t4_data", bus.data_out, 8'h0F);

    send(8'h01, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    idle(CPB);
    check("t5_data", bus.data_out, 8'hFF);

    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    rst = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    idle(2 * CPB);
    check("t6_rst_data", bus.data_out, 8'h00);
    check("t6_rst_busy", bus.busy, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    idle(CPB);
    check("t6_data", bus.data_out, 8'h3C);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b1);
    idle(CPB);
    check("t6_par_hold", bus.data_out, 8'h3C);
`endif

    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic       stop;
      b = 8'($urandom);
      stop = ($urandom_range(0, 9) != 0);
      send(b, stop, 1'b0);
      if (stop) idle($urandom_range(0, 20));
      else idle(CPB + $urandom_range(0, 10));
    end

    idle(3 * CPB);
    check("final_data", bus.data_out, last_good);
    check("queue_drained", exp_q.size(), 0);
    check("final_busy", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
